// File: rtl/digi_ota_cal_ctrl.sv
// rtl/digi_ota_cal_ctrl.sv - OTA offset-trim SAR calibration and windowed duty measurement sequencer
module digi_ota_cal_ctrl #(
    parameter int TRIM_W     = 5,
    parameter int SETTLE_CYC = 16,
    parameter int AVG_N      = 8,
    parameter int WIN_LOG2   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_cal,
    input  logic                run_en,
    input  logic                cmp_in,
    output logic                ota_en,
    output logic                cal_short,
    output logic [TRIM_W-1:0]   trim,
    output logic                cal_busy,
    output logic                cal_done,
    output logic [WIN_LOG2:0]   duty,
    output logic                duty_valid
);

    localparam int CNT_MAX = (SETTLE_CYC > AVG_N) ? SETTLE_CYC : AVG_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ONES_W  = $clog2(AVG_N + 1);
    localparam int BIT_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(AVG_N - 1);
    localparam logic [TRIM_W-1:0] TRIM_MID    = TRIM_W'(1) << (TRIM_W - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP     = BIT_W'(TRIM_W - 1);
    localparam logic [ONES_W:0]   HALF_N      = (ONES_W + 1)'(AVG_N);

    typedef enum logic [2:0] {
        IDLE, CAL_SETTLE, CAL_SAMPLE, CAL_DECIDE, CAL_END, RUN_SETTLE, RUN
    } state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt;
    logic [ONES_W-1:0]   ones;
    logic [BIT_W-1:0]    bidx;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   acc;
    logic                sync1, cmp_s;
    logic                ota_en_d, cal_short_d, cal_busy_d, cal_done_d;
    logic                cal_start;
    logic                majority_high;

    // Calibration can only be launched from the non-calibrating states.
    assign cal_start     = start_cal && (state == IDLE || state == RUN_SETTLE || state == RUN);
    assign majority_high = {ones, 1'b0} > HALF_N;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:       if (start_cal)              next_state = CAL_SETTLE;
                        else if (run_en)            next_state = RUN_SETTLE;
            CAL_SETTLE: if (cnt == SETTLE_LAST)     next_state = CAL_SAMPLE;
            CAL_SAMPLE: if (cnt == SAMPLE_LAST)     next_state = CAL_DECIDE;
            CAL_DECIDE: next_state = (bidx == '0) ? CAL_END : CAL_SETTLE;
            CAL_END:    next_state = IDLE;
            RUN_SETTLE: if (start_cal)              next_state = CAL_SETTLE;
                        else if (!run_en)           next_state = IDLE;
                        else if (cnt == SETTLE_LAST) next_state = RUN;
            RUN:        if (start_cal)              next_state = CAL_SETTLE;
                        else if (!run_en)           next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        ota_en_d    = (next_state != IDLE);
        cal_busy_d  = (next_state == CAL_SETTLE) || (next_state == CAL_SAMPLE) ||
                      (next_state == CAL_DECIDE);
        cal_short_d = cal_busy_d;
        cal_done_d  = (next_state == CAL_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            cmp_s      <= 1'b0;
            ota_en     <= 1'b0;
            cal_short  <= 1'b0;
            cal_busy   <= 1'b0;
            cal_done   <= 1'b0;
            trim       <= TRIM_MID;
            duty       <= '0;
            duty_valid <= 1'b0;
            cnt        <= '0;
            ones       <= '0;
            bidx       <= '0;
            win_cnt    <= '0;
            acc        <= '0;
        end else begin
            sync1      <= cmp_in;
            cmp_s      <= sync1;
            ota_en     <= ota_en_d;
            cal_short  <= cal_short_d;
            cal_busy   <= cal_busy_d;
            cal_done   <= cal_done_d;
            duty_valid <= 1'b0;
            if (cal_start) begin
                trim    <= TRIM_MID;
                bidx    <= BIT_TOP;
                cnt     <= '0;
                ones    <= '0;
                acc     <= '0;
                win_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: cnt <= '0;
                    CAL_SETTLE: cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                    CAL_SAMPLE: begin
                        ones <= ones + ONES_W'(cmp_s);
                        cnt  <= (cnt == SAMPLE_LAST) ? '0 : cnt + 1'b1;
                    end
                    CAL_DECIDE: begin
                        if (majority_high) trim[bidx] <= 1'b0;
                        if (bidx != '0) begin
                            trim[bidx - 1'b1] <= 1'b1;
                            bidx              <= bidx - 1'b1;
                        end
                        ones <= '0;
                    end
                    RUN_SETTLE: begin
                        cnt     <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                        acc     <= '0;
                        win_cnt <= '0;
                    end
                    RUN: if (run_en) begin
                        win_cnt <= win_cnt + 1'b1;
                        if (&win_cnt) begin
                            duty       <= acc + (WIN_LOG2 + 1)'(cmp_s);
                            duty_valid <= 1'b1;
                            acc        <= '0;
                        end else begin
                            acc <= acc + (WIN_LOG2 + 1)'(cmp_s);
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digi_ota_cal_ctrl.sv
// tb/tb_digi_ota_cal_ctrl.sv - self-checking bench for digi_ota_cal_ctrl
module tb_digi_ota_cal_ctrl;

    logic       clk = 1'b0;
    logic       rst, start_cal, run_en, cmp_in;
    logic       ota_en, cal_short, cal_busy, cal_done, duty_valid;
    logic [4:0] trim;
    logic [8:0] duty;

    int checks = 0;
    int errors = 0;
    int cmp_mode = 0;
    int thr = 0;
    int dens = 50;
    bit hist [0:1023];
    int ecnt = 0;

    digi_ota_cal_ctrl #(.TRIM_W(5), .SETTLE_CYC(16), .AVG_N(8), .WIN_LOG2(8)) dut (
        .clk(clk), .rst(rst), .start_cal(start_cal), .run_en(run_en), .cmp_in(cmp_in),
        .ota_en(ota_en), .cal_short(cal_short), .trim(trim), .cal_busy(cal_busy),
        .cal_done(cal_done), .duty(duty), .duty_valid(duty_valid)
    );

    always #5 clk = ~clk;

    // Comparator plant: 0/1 constant, trim threshold, toggle, random density.
    always @(negedge clk) begin
        case (cmp_mode)
            0: cmp_in = 1'b0;
            1: cmp_in = 1'b1;
            2: cmp_in = (int'(trim) >= thr);
            3: cmp_in = ~cmp_in;
            default: cmp_in = ($urandom_range(0, 99) < dens);
        endcase
    end

    always @(posedge clk) begin
        hist[ecnt % 1024] = cmp_in;
        ecnt++;
    end

    // Duty of the window closed at edge e: cmp_in as sampled at edges e-257 .. e-2.
    function automatic int win_sum(int e);
        int s = 0;
        for (int k = e - 257; k <= e - 2; k++) s += int'(hist[k % 1024]);
        return s;
    endfunction

    // Ideal SAR: a bit stays set only when the comparator reads low at the trial code.
    function automatic int sar_model(int threshold);
        int res = 0;
        for (int b = 4; b >= 0; b--) begin
            int t = res | (1 << b);
            if (t < threshold) res = t;
        end
        return res;
    endfunction

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ota_en, cal_short, trim, cal_busy, cal_done, duty, duty_valid} !== {1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s got ota=%0b short=%0b trim=%b busy=%0b done=%0b duty=%0d dv=%0b exp 0 0 10000 0 0 0 0",
                     name, ota_en, cal_short, trim, cal_busy, cal_done, duty, duty_valid);
        end
        @(negedge clk);
        run_en    = 1'b0;
        start_cal = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_cal = 1'b0; run_en = 1'b0; cmp_mode = 0;
        do_reset("reset_init");
        cmp_mode = 1;
        @(negedge clk);
        run_en = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (duty !== 9'd256) begin
            errors++;
            $display("FAIL pre_reset_duty got %0d exp 256", duty);
        end
        do_reset("reset_mid_run");
    endtask

    task automatic test_cal(input string name, input int mode, input int threshold, input int exp_trim,
                            input int hold, input bit run_level);
        int done_cyc = -1, done_cnt = 0, busy_cnt = 0, short_bad = 0, dv_cnt = 0;
        cmp_mode = mode;
        thr      = threshold;
        @(negedge clk);
        start_cal = 1'b1;
        run_en    = run_level;
        for (int c = 1; c <= 135; c++) begin
            @(posedge clk);
            #1;
            if (c >= hold) start_cal = 1'b0;
            if (cal_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (cal_busy) busy_cnt++;
            if (cal_short !== cal_busy) short_bad++;
            if (duty_valid) dv_cnt++;
        end
        checks++;
        if (done_cyc != 126) begin
            errors++;
            $display("FAIL %s_done_latency got %0d exp 126", name, done_cyc);
        end
        checks++;
        if (done_cnt != 1 || busy_cnt != 125) begin
            errors++;
            $display("FAIL %s_pulse got done=%0d busy=%0d exp 1 125", name, done_cnt, busy_cnt);
        end
        checks++;
        if (int'(trim) != exp_trim) begin
            errors++;
            $display("FAIL %s_trim got %0d exp %0d", name, trim, exp_trim);
        end
        checks++;
        if (short_bad != 0 || dv_cnt != 0) begin
            errors++;
            $display("FAIL %s_short_dv got short_bad=%0d dv=%0d exp 0 0", name, short_bad, dv_cnt);
        end
        @(negedge clk);
        run_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_run_windows();
        int nvalid = 0;
        cmp_mode = 1;
        @(negedge clk);
        run_en = 1'b1;
        for (int c = 1; c <= 1045; c++) begin
            @(posedge clk);
            #1;
            if (c == 271) cmp_mode = 3;
            if (c == 527) begin cmp_mode = 4; dens = 25; end
            if (c == 783) dens = 75;
            if (duty_valid) begin
                nvalid++;
                checks++;
                if (c != 273 + 256 * (nvalid - 1)) begin
                    errors++;
                    $display("FAIL win%0d_timing got %0d exp %0d", nvalid, c, 273 + 256 * (nvalid - 1));
                end
                checks++;
                if (int'(duty) != win_sum(ecnt - 1)) begin
                    errors++;
                    $display("FAIL win%0d_duty got %0d exp %0d", nvalid, duty, win_sum(ecnt - 1));
                end
                if (nvalid == 1 || nvalid == 2) begin
                    checks++;
                    if (int'(duty) != (nvalid == 1 ? 256 : 128)) begin
                        errors++;
                        $display("FAIL win%0d_const got %0d exp %0d", nvalid, duty, nvalid == 1 ? 256 : 128);
                    end
                end
            end
        end
        checks++;
        if (nvalid != 4) begin
            errors++;
            $display("FAIL run_valid_count got %0d exp 4", nvalid);
        end
        @(negedge clk);
        run_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_run_drop();
        int seen = 0, dv_after = 0;
        logic [8:0] last;
        cmp_mode = 4; dens = 60;
        @(negedge clk);
        run_en = 1'b1;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (duty_valid) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL drop_first_window got no duty_valid exp one within 400 cycles");
        end
        last = duty;
        repeat (100) @(posedge clk);
        @(negedge clk);
        run_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ota_en !== 1'b0) begin
            errors++;
            $display("FAIL drop_ota_en got %0b exp 0", ota_en);
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (duty_valid) dv_after++;
        end
        checks++;
        if (dv_after != 0 || duty !== last) begin
            errors++;
            $display("FAIL drop_hold got dv=%0d duty=%0d exp 0 %0d", dv_after, duty, last);
        end
    endtask

    task automatic test_cal_in_run();
        int t;
        cmp_mode = 4; dens = 40;
        @(negedge clk);
        run_en = 1'b1;
        repeat (66) @(posedge clk);
        t = $urandom_range(1, 31);
        test_cal("cal_in_run", 2, t, sar_model(t), 1, 1'b1);
    endtask

    task automatic test_reset_mid_cal();
        cmp_mode = 0;
        @(negedge clk);
        start_cal = 1'b1;
        @(negedge clk);
        start_cal = 1'b0;
        repeat (60) @(posedge clk);
        do_reset("reset_mid_cal");
    endtask

    initial begin
        test_reset();
        test_cal("cal_ones", 1, 0, 0, 1, 1'b0);
        test_cal("cal_zeros_held_start", 0, 0, 31, 100, 1'b0);
        test_cal("cal_thr13", 2, 13, 12, 1, 1'b0);
        test_cal("cal_tie", 3, 0, 31, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int t = $urandom_range(0, 32);
            test_cal($sformatf("cal_rand%0d", i), 2, t, sar_model(t), 1, 1'b0);
        end
        test_run_windows();
        test_run_drop();
        test_cal_in_run();
        test_reset_mid_cal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
